// File: rtl/counter_pkg.sv
// Shared types and constants for the counter gate sequencer and its gate timer.
package counter_pkg;

    localparam int CNT_W_DEFAULT = 32;
    localparam int GATE_LEN_W    = 32;
    // Two cycles of channel counter pipeline plus one cycle of margin.
    localparam int SETTLE_CYC    = 3;
    localparam int SETTLE_W      = $clog2(SETTLE_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATE,
        ST_SETTLE,
        ST_LATCH
    } seq_state_e;

    // A zero-length request still opens the gate for one cycle.
    function automatic logic [GATE_LEN_W-1:0] clamp_gate_len(input logic [GATE_LEN_W-1:0] len);
        return (len == '0) ? GATE_LEN_W'(1) : len;
    endfunction

endpackage

// File: rtl/gate_timer.sv
// Gate duration down-counter: loaded with the gate length, ticked once per
// gate cycle, pulses o_done during the last gate cycle.
module gate_timer
    import counter_pkg::*;
#(
    parameter int LEN_W = GATE_LEN_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_tick,
    output logic             o_done
);

    logic [LEN_W-1:0] remain_q;
    logic [LEN_W-1:0] remain_d;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        remain_d = remain_q;
        if (i_load) begin
            remain_d = i_len;
        end else if (i_tick && (remain_q != '0)) begin
            remain_d = remain_q - LEN_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update
    // together at the edge regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            remain_q <= '0;
        end else begin
            remain_q <= remain_d;
        end
    end

    assign o_done = i_tick && (remain_q == LEN_W'(1));

endmodule

// File: rtl/counter_gate_sequencer.sv
// Sequences clear / gate / settle / latch over a bank of external channel
// counters and hands the latched counts to a consumer with valid/ack.
module counter_gate_sequencer
    import counter_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_continuous,
    input  logic [31:0]           i_gate_len,
    input  logic [N_CH*CNT_W-1:0] i_counts,
    input  logic                  i_ack,
    output logic                  o_gate,
    output logic                  o_cnt_reset,
    output logic [N_CH*CNT_W-1:0] o_latched,
    output logic                  o_valid,
    output logic                  o_overrun,
    output logic [15:0]           o_seq,
    output logic                  o_busy
);

    seq_state_e state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;

    logic gate_q;
    logic cnt_reset_q;

    logic [N_CH*CNT_W-1:0] latched_q;
    logic                  valid_q;
    logic                  overrun_q;
    logic [15:0]           seq_q;

    logic timer_load;
    logic timer_tick;
    logic timer_done;

    logic start_ok;
    logic latch_fire;

    assign start_ok   = (state_q == ST_IDLE) && i_start && !i_stop;
    assign latch_fire = (state_q == ST_LATCH) && !i_stop;

    gate_timer #(
        .LEN_W (GATE_LEN_W)
    ) u_gate_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (timer_load),
        .i_len   (clamp_gate_len(i_gate_len)),
        .i_tick  (timer_tick),
        .o_done  (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        timer_load = 1'b0;
        timer_tick = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                timer_load = 1'b1;
                state_d    = ST_GATE;
            end
            ST_GATE: begin
                timer_tick = 1'b1;
                if (timer_done) begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_W'(SETTLE_CYC - 1);
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_LATCH;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            ST_LATCH: begin
                state_d = i_continuous ? ST_CLEAR : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (i_stop) begin
            state_d = ST_IDLE;
        end
    end

    // Gate and counter-reset are decoded from the next state so they are
    // plain flops aligned with the state they belong to.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            gate_q      <= 1'b0;
            cnt_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            gate_q      <= (state_d == ST_GATE);
            cnt_reset_q <= (state_d == ST_CLEAR);
        end
    end

    // NOTE: the snapshot register is wide but still reset, because consumers
    // must see all-zero counts while reset is held.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            latched_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            seq_q     <= '0;
        end else if (latch_fire) begin
            latched_q <= i_counts;
            valid_q   <= 1'b1;
            seq_q     <= seq_q + 16'd1;
            if (valid_q && !i_ack) begin
                overrun_q <= 1'b1;
            end
        end else begin
            if (i_ack && valid_q) begin
                valid_q <= 1'b0;
            end
            if (start_ok) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign o_gate      = gate_q;
    assign o_cnt_reset = cnt_reset_q;
    assign o_latched   = latched_q;
    assign o_valid     = valid_q;
    assign o_overrun   = overrun_q;
    assign o_seq       = seq_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_counter_gate_sequencer.sv
// Directed bench with a channel-counter model and a snapshot scoreboard.
module tb_counter_gate_sequencer;

    localparam int N_CH  = 4;
    localparam int CNT_W = 32;
    localparam int BUS_W = N_CH * CNT_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              i_reset      = 1'b1;
    logic              i_start      = 1'b0;
    logic              i_stop       = 1'b0;
    logic              i_continuous = 1'b0;
    logic [31:0]       i_gate_len   = 32'd0;
    logic              i_ack        = 1'b0;
    logic [BUS_W-1:0]  i_counts;
    logic              o_gate, o_cnt_reset, o_valid, o_overrun, o_busy;
    logic [BUS_W-1:0]  o_latched;
    logic [15:0]       o_seq;

    counter_gate_sequencer #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_continuous (i_continuous),
        .i_gate_len   (i_gate_len),
        .i_counts     (i_counts),
        .i_ack        (i_ack),
        .o_gate       (o_gate),
        .o_cnt_reset  (o_cnt_reset),
        .o_latched    (o_latched),
        .o_valid      (o_valid),
        .o_overrun    (o_overrun),
        .o_seq        (o_seq),
        .o_busy       (o_busy)
    );

    // Channel counter model: gate reaches the count through two pipeline flops.
    logic [CNT_W-1:0] inc    [N_CH];
    logic [CNT_W-1:0] ch_cnt [N_CH];
    logic g1 = 1'b0, g2 = 1'b0;

    always @(posedge clk) begin
        g1 <= o_gate;
        g2 <= g1;
        for (int k = 0; k < N_CH; k++) begin
            if (o_cnt_reset)  ch_cnt[k] <= '0;
            else if (g2)      ch_cnt[k] <= ch_cnt[k] + inc[k];
        end
    end

    always_comb begin
        i_counts = '0;
        for (int k = 0; k < N_CH; k++) i_counts[k*CNT_W +: CNT_W] = ch_cnt[k];
    end

    typedef struct {
        logic [BUS_W-1:0] latched;
        logic [15:0]      seq;
        logic             overrun;
    } snap_t;

    snap_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [15:0] prev_seq;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [BUS_W-1:0] exp_bus(input int len);
        logic [BUS_W-1:0] b;
        b = '0;
        for (int k = 0; k < N_CH; k++) b[k*CNT_W +: CNT_W] = CNT_W'(len) * inc[k];
        return b;
    endfunction

    task automatic push(input int len, input int seq, input logic ov);
        snap_t s;
        s.latched = exp_bus(len);
        s.seq     = 16'(seq);
        s.overrun = ov;
        exp_q.push_back(s);
    endtask

    task automatic set_inc(input logic ramp);
        for (int k = 0; k < N_CH; k++) inc[k] = ramp ? CNT_W'(k + 1) : CNT_W'(1);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_meas(input logic [31:0] len, input logic cont);
        i_gate_len   = len;
        i_continuous = cont;
        i_start      = 1'b1;
        step();
        i_start      = 1'b0;
    endtask

    task automatic measure_gate(output int n);
        n = 0;
        for (int w = 0; w < 20 && !o_gate; w++) step();
        while (o_gate && n < 2000) begin
            n++;
            step();
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && o_busy; k++) step();
        check("idle_timeout", o_busy, 0);
    endtask

    task automatic wait_seq(input int target, input int budget, output int at);
        for (int k = 0; k < budget && o_seq != 16'(target); k++) step();
        check("seq_timeout", o_seq, target);
        at = cyc;
    endtask

    task automatic do_ack();
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        check("ack_clears_valid", o_valid, 0);
    endtask

    // Scoreboard monitor: a change of o_seq outside reset is a snapshot.
    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!i_reset && o_seq !== prev_seq) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_snapshot: seq=%0d with no snapshot expected", o_seq);
                end else begin
                    e = exp_q.pop_front();
                    check("snap_seq", o_seq, e.seq);
                    check("snap_latched", o_latched, e.latched);
                    check("snap_overrun", o_overrun, e.overrun);
                    check("snap_valid", o_valid, 1);
                end
            end
            prev_seq = o_seq;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n, t4, t5, t6;
        set_inc(1'b0);

        // Reset values.
        step(3);
        check("rst_cnt_reset", o_cnt_reset, 1);
        check("rst_gate", o_gate, 0);
        check("rst_busy", o_busy, 0);
        check("rst_valid", o_valid, 0);
        check("rst_seq", o_seq, 0);
        check("rst_latched", o_latched, 0);
        i_reset = 1'b0;
        step();
        check("idle_cnt_reset", o_cnt_reset, 0);
        check("idle_busy", o_busy, 0);

        // Single gate of 10, one pulse per cycle on every channel.
        push(10, 1, 1'b0);
        start_meas(32'd10, 1'b0);
        check("lat_cnt_reset", o_cnt_reset, 1);
        check("lat_gate_low", o_gate, 0);
        check("lat_busy", o_busy, 1);
        step();
        check("lat_gate_high", o_gate, 1);
        check("lat_cnt_reset_off", o_cnt_reset, 0);
        measure_gate(n);
        check("gate_len_10", n, 10);
        wait_idle(20);
        check("single_valid", o_valid, 1);
        check("single_overrun", o_overrun, 0);
        do_ack();

        // Zero length opens the gate for exactly one cycle.
        set_inc(1'b1);
        push(1, 2, 1'b0);
        start_meas(32'd0, 1'b0);
        measure_gate(n);
        check("gate_len_0", n, 1);
        wait_idle(20);
        do_ack();

        // Gate length changed mid-gate has no effect.
        set_inc(1'b0);
        push(3, 3, 1'b0);
        start_meas(32'd3, 1'b0);
        step();
        i_gate_len = 32'd50;
        measure_gate(n);
        check("gate_len_frozen", n, 3);
        wait_idle(20);
        do_ack();

        // Continuous mode without ack: period 9, overrun from 2nd snapshot.
        set_inc(1'b1);
        push(4, 4, 1'b0);
        push(4, 5, 1'b1);
        push(4, 6, 1'b1);
        start_meas(32'd4, 1'b1);
        wait_seq(4, 40, t4);
        step(2);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        wait_seq(5, 40, t5);
        check("cont_period_1", t5 - t4, 9);
        check("cont_overrun", o_overrun, 1);
        wait_seq(6, 40, t6);
        check("cont_period_2", t6 - t5, 9);
        i_continuous = 1'b0;
        i_stop       = 1'b1;
        step();
        i_stop       = 1'b0;
        check("cont_stop_idle", o_busy, 0);
        check("cont_stop_gate", o_gate, 0);
        check("overrun_sticky", o_overrun, 1);
        check("cont_stop_seq", o_seq, 6);

        // Ack coinciding with the latch edge.
        set_inc(1'b0);
        push(2, 7, 1'b0);
        start_meas(32'd2, 1'b0);
        check("start_clears_overrun", o_overrun, 0);
        measure_gate(n);
        check("gate_len_2", n, 2);
        step(3);
        check("pre_latch_seq", o_seq, 6);
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        check("ack_latch_seq", o_seq, 7);
        check("ack_latch_valid", o_valid, 1);
        check("ack_latch_overrun", o_overrun, 0);
        wait_idle(5);
        do_ack();

        // Stop in gate cycle 5 of 100.
        start_meas(32'd100, 1'b0);
        step(5);
        check("stop_gate_on", o_gate, 1);
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        check("stop_gate_off", o_gate, 0);
        check("stop_idle", o_busy, 0);
        check("stop_seq", o_seq, 7);
        check("stop_latched", o_latched, exp_bus(2));
        check("stop_valid", o_valid, 0);

        // Stop wins over a simultaneous start.
        i_start = 1'b1;
        i_stop  = 1'b1;
        step();
        i_start = 1'b0;
        i_stop  = 1'b0;
        step();
        check("stop_priority", o_busy, 0);

        // Reset pulsed during SETTLE.
        start_meas(32'd5, 1'b0);
        measure_gate(n);
        check("gate_len_5", n, 5);
        i_reset = 1'b1;
        step();
        check("mid_rst_cnt_reset", o_cnt_reset, 1);
        check("mid_rst_gate", o_gate, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_seq", o_seq, 0);
        check("mid_rst_latched", o_latched, 0);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_overrun", o_overrun, 0);
        step();
        i_reset = 1'b0;
        step();
        check("post_rst_cnt_reset", o_cnt_reset, 0);
        step(10);
        check("post_rst_busy", o_busy, 0);
        check("post_rst_seq", o_seq, 0);
        check("post_rst_valid", o_valid, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_gate_sequencer.md
COUNTER_GATE_SEQUENCER -- requirements
Module: counter_gate_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning the number of input_counter channels sequenced.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of each channel count.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_start, input, 1 bit: starts a measurement; honoured only in IDLE.
REQ-006 SHALL have port i_stop, input, 1 bit: aborts any measurement.
REQ-007 SHALL have port i_continuous, input, 1 bit: 1 means repeat gates back-to-back, 0 means a single gate.
REQ-008 SHALL have port i_gate_len, input, 32 bits: gate duration in clock cycles.
REQ-009 SHALL have port i_counts, input, N_CH*CNT_W bits: live o_count buses from the channels, with channel 0 in the LSBs.
REQ-010 SHALL have port i_ack, input, 1 bit: the consumer acknowledges o_latched.
REQ-011 SHALL have port o_gate, output, 1 bit: drives i_gate of every channel.
REQ-012 SHALL have port o_cnt_reset, output, 1 bit: drives i_reset of every channel.
REQ-013 SHALL have port o_latched, output, N_CH*CNT_W bits: snapshot of i_counts at the end of a gate.
REQ-014 SHALL have port o_valid, output, 1 bit: o_latched holds unacknowledged data.
REQ-015 SHALL have port o_overrun, output, 1 bit: sticky flag meaning a snapshot replaced unacknowledged data.
REQ-016 SHALL have port o_seq, output, 16 bits: count of completed snapshots; wraps from 0xFFFF to 0.
REQ-017 SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, CLEAR, GATE, SETTLE and LATCH.
REQ-019 SHALL move IDLE to CLEAR on the edge where i_start=1 and i_stop=0.
REQ-020 SHALL assert o_cnt_reset in CLEAR, for exactly 1 cycle.
REQ-021 SHALL sample i_gate_len in CLEAR, as L = max(i_gate_len, 1); a change to i_gate_len during GATE has no effect.
REQ-022 SHALL hold o_gate=1 in GATE for exactly L consecutive cycles, then move to SETTLE.
REQ-023 SHALL stay in SETTLE for SETTLE_CYC=3 cycles with o_gate=0, covering the 2-cycle counter pipeline plus 1 cycle of margin.
REQ-024 SHALL, in LATCH (1 cycle), load o_latched from i_counts, set o_valid and increment o_seq at the closing edge.
REQ-025 SHALL, after LATCH, move to CLEAR if i_continuous=1, otherwise to IDLE.
REQ-026 SHALL make the start-to-first-gate latency exactly 2 cycles: i_start sampled at edge t gives o_cnt_reset high in cycle t+1 and o_gate high from cycle t+2.
REQ-027 SHALL make the continuous-mode period L+5 cycles.
REQ-028 SHALL, on i_stop=1 in any state, go to IDLE at the next edge: o_gate=0, no snapshot, o_valid, o_latched and o_seq unchanged.
REQ-029 SHALL give i_stop priority when i_start and i_stop are both 1.
REQ-030 SHALL ignore i_start outside IDLE.
REQ-031 SHALL clear o_valid at the next edge when i_ack=1 and o_valid=1; i_ack with o_valid=0 is ignored.
REQ-032 SHALL, when LATCH occurs while o_valid=1 and i_ack=0, overwrite o_latched and set o_overrun.
REQ-033 SHALL, when LATCH and i_ack coincide, leave o_valid=1 with o_overrun unchanged.
REQ-034 SHALL clear o_overrun only on i_reset or on an accepted i_start.
REQ-035 SHALL register o_gate and o_cnt_reset directly as decoded state flops, with no combinational path from any input.

Reset
REQ-036 SHALL, while i_reset=1, force state IDLE and o_gate=0.
REQ-037 SHALL, while i_reset=1, force o_cnt_reset=1 so the channels are held cleared.
REQ-038 SHALL, while i_reset=1, force o_latched=0, o_valid=0, o_overrun=0, o_seq=0 and o_busy=0.
REQ-039 SHALL abort a measurement in progress when reset is asserted mid-operation, with no snapshot.
REQ-040 SHALL, after reset is released, hold every output at its idle value (o_cnt_reset=0) until i_start.

Structure
REQ-041 SHALL place the state enum typedef, the SETTLE_CYC constant and the CNT_W default in the shared package counter_pkg.
REQ-042 SHALL place the gate duration down-counter in sub-module gate_timer (load L, tick, done pulse).
REQ-043 SHALL keep the channel counters outside this block; it only drives their gate and reset.

Verification
REQ-044 SHALL cover single gate: i_gate_len=10, 1 pulse per cycle on all channels -> o_gate high 10 cycles, o_latched=10 on every channel, o_valid=1, o_seq=1, return to IDLE.
REQ-045 SHALL cover zero length: i_gate_len=0 -> o_gate high exactly 1 cycle, snapshot=1.
REQ-046 SHALL cover continuous mode without ack: i_gate_len=4, i_continuous=1 -> snapshots every 9 cycles, o_overrun=1 from the 2nd snapshot, o_seq increments each time.
REQ-047 SHALL cover ack at the latch edge: i_ack asserted in the LATCH cycle -> o_valid stays 1, o_overrun stays 0.
REQ-048 SHALL cover stop mid-gate: i_stop in gate cycle 5 of 100 -> o_gate=0 next cycle, IDLE, o_seq and o_latched unchanged.
REQ-049 SHALL cover reset mid-SETTLE: i_reset pulsed -> all outputs at reset values, o_cnt_reset=1 during reset, no snapshot.
